// File: rtl/compositor_pkg.sv
// Shared types and constants for the layer compositor.
// Holds the fade FSM state enum, the packed rgb_t pixel type,
// the background gradient constants and the full-brightness fade level.
package compositor_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FADING = 2'd1,
    DONE   = 2'd2
  } fade_state_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  localparam logic [7:0] BG_R      = 8'h3F;
  localparam logic [7:0] BG_G      = 8'h00;
  localparam logic [7:0] BG_B_BASE = 8'h7F;

  localparam int unsigned FADE_FULL = 256;

  // (c * level) >> 8; 255 * 256 still fits in 16 bits, so level 256 is identity.
  function automatic logic [7:0] fade_scale(input logic [7:0] c, input logic [8:0] level);
    logic [15:0] prod;
    prod = 16'(c) * 16'(level);
    return prod[15:8];
  endfunction

endpackage

// File: rtl/compositor_palette_ram.sv
// Palette RAM: 2**IDX_W x 24-bit, one write port, one synchronous read port.
// Ports: clk; wr_en/wr_addr/wr_data write at the rising edge;
//        rd_addr sampled at the rising edge, rd_data valid after it (old data on collision).
module compositor_palette_ram #(
  parameter int IDX_W = 5
) (
  input  logic             clk,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_addr,
  input  logic [23:0]      wr_data,
  input  logic [IDX_W-1:0] rd_addr,
  output logic [23:0]      rd_data
);

  logic [23:0] mem_q [2**IDX_W];
  logic [23:0] rd_data_q;

  // Contents are deliberately not reset. Read and write share one block so a
  // same-edge read of the written address returns the pre-write value.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
    rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/layer_compositor.sv
// Layer compositor: priority-selects the top opaque layer, looks up its palette
// colour (or a background gradient) and applies an optional frame-stepped fade.
// Ports: Clk, Reset_n (sync, active-low); DrawX, pix_valid, layer_hit, layer_idx in;
//        pal_wr_* palette write; frame_start/fade_req/fade_dir fade control;
//        VGA_R/G/B, out_valid (3-cycle latency, never stalls), fade_busy, fade_done out.
// Build option: define COMPOSITOR_FADE_EN to include the fade FSM and scaling;
// without it stage 3 is a plain register and the fade outputs are tied low.
module layer_compositor
  import compositor_pkg::*;
#(
  parameter int NUM_LAYERS = 6,
  parameter int IDX_W      = 5,
  parameter int FADE_STEP  = 8
) (
  input  logic                        Clk,
  input  logic                        Reset_n,
  input  logic [9:0]                  DrawX,
  input  logic                        pix_valid,
  input  logic [NUM_LAYERS-1:0]       layer_hit,
  input  logic [NUM_LAYERS*IDX_W-1:0] layer_idx,
  input  logic                        pal_wr_en,
  input  logic [IDX_W-1:0]            pal_wr_addr,
  input  logic [23:0]                 pal_wr_data,
  input  logic                        frame_start,
  input  logic                        fade_req,
  input  logic                        fade_dir,
  output logic [7:0]                  VGA_R,
  output logic [7:0]                  VGA_G,
  output logic [7:0]                  VGA_B,
  output logic                        out_valid,
  output logic                        fade_busy,
  output logic                        fade_done
);

  // Priority select
  logic             win_found;
  logic [IDX_W-1:0] win_idx;

  // Stage 1: winner or background flag. Only DrawX[9:3] feeds the gradient.
  logic             vld1_q, vld1_d;
  logic             bg1_q, bg1_d;
  logic [IDX_W-1:0] idx1_q, idx1_d;
  logic [6:0]       dx1_q, dx1_d;

  // Stage 2: palette RAM output register plus registered gradient.
  logic vld2_q, vld2_d;
  logic bg2_q, bg2_d;
  rgb_t grad2_q, grad2_d;
  rgb_t pal_rd;

  // Stage 3: output register.
  rgb_t pix;
  rgb_t rgb3_q, rgb3_d;
  logic vld3_q, vld3_d;

  logic unused_drawx;
  assign unused_drawx = ^DrawX[2:0];

  // Walk from the lowest-priority layer upwards so the last hit (lowest i) wins.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
      if (layer_hit[i] && (layer_idx[i*IDX_W +: IDX_W] != '0)) begin
        win_found = 1'b1;
        win_idx   = layer_idx[i*IDX_W +: IDX_W];
      end
    end
  end

  always_comb begin
    vld1_d    = pix_valid;
    bg1_d     = ~win_found;
    idx1_d    = win_idx;
    dx1_d     = DrawX[9:3];
    vld2_d    = vld1_q;
    bg2_d     = bg1_q;
    grad2_d.r = BG_R;
    grad2_d.g = BG_G;
    grad2_d.b = BG_B_BASE - {1'b0, dx1_q};
  end

  compositor_palette_ram #(
    .IDX_W(IDX_W)
  ) u_palette (
    .clk     (Clk),
    .wr_en   (pal_wr_en),
    .wr_addr (pal_wr_addr),
    .wr_data (pal_wr_data),
    .rd_addr (idx1_q),
    .rd_data (pal_rd)
  );

`ifdef COMPOSITOR_FADE_EN
  localparam logic [8:0] STEP_L = 9'(FADE_STEP);
  localparam logic [8:0] FULL_L = 9'(FADE_FULL);

  fade_state_e state_q, state_d;
  logic [8:0]  level_q, level_d;
  logic        dir_q, dir_d;
  logic [8:0]  target;
  logic [9:0]  up_sum;

  always_comb begin
    state_d = state_q;
    level_d = level_q;
    dir_d   = dir_q;
    target  = '0;
    up_sum  = '0;

    case (state_q)
      IDLE: begin
        if (fade_req) begin
          dir_d   = fade_dir;
          state_d = FADING;
        end
      end
      FADING: begin
        // A request mid-fade just turns around; the level is kept.
        if (fade_req) begin
          dir_d = ~dir_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // The step uses the direction after any same-cycle request.
    if ((state_d == FADING) && frame_start) begin
      if (dir_d) begin
        level_d = (level_q > STEP_L) ? (level_q - STEP_L) : 9'd0;
      end else begin
        up_sum  = {1'b0, level_q} + {1'b0, STEP_L};
        level_d = (up_sum >= {1'b0, FULL_L}) ? FULL_L : up_sum[8:0];
      end
    end

    // Only an already-running fade can finish, so a request toward the
    // current target still spends one cycle in FADING before DONE.
    target = dir_d ? 9'd0 : FULL_L;
    if ((state_q == FADING) && (level_d == target)) begin
      state_d = DONE;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      level_q <= FULL_L;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      dir_q   <= dir_d;
    end
  end

  assign fade_busy = (state_q != IDLE);
  assign fade_done = (state_q == DONE);
`else
  logic unused_fade;
  assign unused_fade = ^{frame_start, fade_req, fade_dir, 32'(FADE_STEP), 32'(FADE_FULL)};
  assign fade_busy   = 1'b0;
  assign fade_done   = 1'b0;
`endif

  always_comb begin
    pix    = bg2_q ? grad2_q : pal_rd;
    vld3_d = vld2_q;
    rgb3_d = '0;
    if (vld2_q) begin
`ifdef COMPOSITOR_FADE_EN
      rgb3_d.r = fade_scale(pix.r, level_q);
      rgb3_d.g = fade_scale(pix.g, level_q);
      rgb3_d.b = fade_scale(pix.b, level_q);
`else
      rgb3_d = pix;
`endif
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      vld1_q  <= 1'b0;
      bg1_q   <= 1'b0;
      idx1_q  <= '0;
      dx1_q   <= '0;
      vld2_q  <= 1'b0;
      bg2_q   <= 1'b0;
      grad2_q <= '0;
      vld3_q  <= 1'b0;
      rgb3_q  <= '0;
    end else begin
      vld1_q  <= vld1_d;
      bg1_q   <= bg1_d;
      idx1_q  <= idx1_d;
      dx1_q   <= dx1_d;
      vld2_q  <= vld2_d;
      bg2_q   <= bg2_d;
      grad2_q <= grad2_d;
      vld3_q  <= vld3_d;
      rgb3_q  <= rgb3_d;
    end
  end

  assign VGA_R     = rgb3_q.r;
  assign VGA_G     = rgb3_q.g;
  assign VGA_B     = rgb3_q.b;
  assign out_valid = vld3_q;

endmodule

// File: tb/tb_layer_compositor.sv
// Self-checking bench for layer_compositor: directed scenarios plus random
// traffic, every cycle compared against a cycle-level behavioural model.
// Works with or without COMPOSITOR_FADE_EN defined.
module tb_layer_compositor;

  localparam int NL   = 6;
  localparam int IW   = 5;
  localparam int STEP = 64;
`ifdef COMPOSITOR_FADE_EN
  localparam int FADE_ON = 1;
`else
  localparam int FADE_ON = 0;
`endif

  logic              Clk = 1'b0;
  logic              Reset_n;
  logic [9:0]        DrawX;
  logic              pix_valid;
  logic [NL-1:0]     layer_hit;
  logic [NL*IW-1:0]  layer_idx;
  logic              pal_wr_en;
  logic [IW-1:0]     pal_wr_addr;
  logic [23:0]       pal_wr_data;
  logic              frame_start, fade_req, fade_dir;
  logic [7:0]        VGA_R, VGA_G, VGA_B;
  logic              out_valid, fade_busy, fade_done;

  layer_compositor #(.NUM_LAYERS(NL), .IDX_W(IW), .FADE_STEP(STEP)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .DrawX(DrawX), .pix_valid(pix_valid),
    .layer_hit(layer_hit), .layer_idx(layer_idx), .pal_wr_en(pal_wr_en),
    .pal_wr_addr(pal_wr_addr), .pal_wr_data(pal_wr_data), .frame_start(frame_start),
    .fade_req(fade_req), .fade_dir(fade_dir), .VGA_R(VGA_R), .VGA_G(VGA_G),
    .VGA_B(VGA_B), .out_valid(out_valid), .fade_busy(fade_busy), .fade_done(fade_done)
  );

  always #5 Clk = ~Clk;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;

  // Reference model state
  logic [23:0] m_pal [2**IW];
  bit          s1_v, s1_bg;
  int          s1_idx, s1_dx;
  bit          s2_v;
  logic [23:0] s2_rgb;
  logic [23:0] m_rgb;
  bit          m_vld, m_busy, m_done, mdir;
  int          lvl = 256;
  int          st  = 0;   // 0 idle, 1 fading, 2 done

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] scale8(input logic [7:0] c, input int l);
    return 8'((int'(c) * l) / 256);
  endfunction

  function automatic int step_level(input int l, input bit down);
    if (down) return (l - STEP < 0) ? 0 : l - STEP;
    return (l + STEP > 256) ? 256 : l + STEP;
  endfunction

  function automatic logic [23:0] rgb_now();
    return {VGA_R, VGA_G, VGA_B};
  endfunction

  task automatic model_edge();
    logic [23:0] n_rgb, n_s2rgb;
    bit          n_s1bg;
    int          n_s1idx;
    n_rgb   = s2_v ? {scale8(s2_rgb[23:16], lvl), scale8(s2_rgb[15:8], lvl), scale8(s2_rgb[7:0], lvl)} : 24'h0;
    n_s2rgb = s1_bg ? {8'h3F, 8'h00, 8'(127 - s1_dx / 8)} : m_pal[s1_idx];
    n_s1bg  = 1'b1;
    n_s1idx = 0;
    for (int i = 0; i < NL; i++) begin
      if (n_s1bg && layer_hit[i] && layer_idx[i*IW +: IW] != 0) begin
        n_s1bg  = 1'b0;
        n_s1idx = int'(layer_idx[i*IW +: IW]);
      end
    end
    if (pal_wr_en) m_pal[pal_wr_addr] = pal_wr_data;
    if (!Reset_n) begin
      s1_v = 0; s2_v = 0; m_vld = 0; m_rgb = 0; s1_bg = 0; s1_idx = 0; s1_dx = 0; s2_rgb = 0;
      lvl = 256; st = 0; mdir = 0;
    end else begin
      m_rgb  = n_rgb;
      m_vld  = s2_v;
      s2_v   = s1_v;
      s2_rgb = n_s2rgb;
      s1_v   = pix_valid;
      s1_bg  = n_s1bg;
      s1_idx = n_s1idx;
      s1_dx  = int'(DrawX);
`ifdef COMPOSITOR_FADE_EN
      case (st)
        0: if (fade_req) begin
             mdir = fade_dir;
             st = 1;
             if (frame_start) lvl = step_level(lvl, mdir);
           end
        1: begin
             if (fade_req) mdir = !mdir;
             if (frame_start) lvl = step_level(lvl, mdir);
             if (lvl == (mdir ? 0 : 256)) st = 2;
           end
        default: st = 0;
      endcase
`endif
    end
    m_busy = (st != 0);
    m_done = (st == 2);
  endtask

  task automatic tick();
    @(posedge Clk);
    model_edge();
    #1;
    check("rgb", {8'h0, rgb_now()}, {8'h0, m_rgb});
    check("out_valid", {31'h0, out_valid}, {31'h0, m_vld});
    check("fade_busy", {31'h0, fade_busy}, {31'h0, m_busy});
    check("fade_done", {31'h0, fade_done}, {31'h0, m_done});
    if (fade_done) done_cnt++;
    pal_wr_en = 1'b0;
    frame_start = 1'b0;
    fade_req = 1'b0;
  endtask

  task automatic clear_pix();
    pix_valid = 1'b0;
    layer_hit = '0;
    layer_idx = '0;
    DrawX = '0;
  endtask

  task automatic set_layer(input int i, input logic [IW-1:0] idx);
    layer_hit[i] = 1'b1;
    layer_idx[i*IW +: IW] = idx;
  endtask

  task automatic pal_write(input logic [IW-1:0] a, input logic [23:0] d);
    pal_wr_en = 1'b1;
    pal_wr_addr = a;
    pal_wr_data = d;
    tick();
  endtask

  initial begin
    int base;
    Reset_n = 1'b0;
    clear_pix();
    pal_wr_en = 0; pal_wr_addr = 0; pal_wr_data = 0;
    frame_start = 0; fade_req = 0; fade_dir = 0;
    repeat (3) tick();
    check("reset_rgb", {8'h0, rgb_now()}, 32'h0);
    check("reset_busy", {31'h0, fade_busy}, 32'h0);
    Reset_n = 1'b1;

    for (int a = 0; a < 2**IW; a++) pal_write(IW'(a), 24'($urandom));
    pal_write(5'd3, 24'hC36633);
    pal_write(5'd5, 24'hF9FF00);
    pal_write(5'd9, 24'h000000);
    pal_write(5'd10, 24'hFFFFFF);

    // Layers 1 and 4 hit: layer 1 wins.
    set_layer(1, 5'd3); set_layer(4, 5'd7); pix_valid = 1; tick();
    clear_pix(); tick(); tick();
    check("prio_l1", {8'h0, rgb_now()}, 32'hC36633);

    // Layer 0 transparent, layer 2 wins.
    set_layer(0, 5'd0); set_layer(2, 5'd5); pix_valid = 1; tick();
    clear_pix(); tick(); tick();
    check("transparent_l0", {8'h0, rgb_now()}, 32'hF9FF00);

    // Background gradient.
    DrawX = 10'd80; pix_valid = 1; tick();
    clear_pix(); tick(); tick();
    check("bg_gradient", {8'h0, rgb_now()}, 32'h3F0075);

    // Palette read collides with a write to the same address.
    set_layer(0, 5'd9); pix_valid = 1; tick();
    pal_wr_en = 1; pal_wr_addr = 5'd9; pal_wr_data = 24'hFFFFFF; tick();
    clear_pix(); tick();
    check("rdw_old", {8'h0, rgb_now()}, 32'h000000);
    tick();
    check("rdw_new", {8'h0, rgb_now()}, 32'hFFFFFF);

    // pix_valid 1,0,1
    pix_valid = 1; tick(); pix_valid = 0; tick(); pix_valid = 1; tick();
    check("vld_seq1", {31'h0, out_valid}, 32'd1);
    pix_valid = 0; tick();
    check("vld_seq0", {31'h0, out_valid}, 32'd0);
    tick();
    check("vld_seq1b", {31'h0, out_valid}, 32'd1);
    tick();

    // Fade out in 4 steps on a white pixel.
    clear_pix(); set_layer(0, 5'd10); pix_valid = 1;
    base = done_cnt;
    fade_req = 1; fade_dir = 1; tick();
    for (int k = 1; k <= 4; k++) begin
      frame_start = 1; tick(); tick();
      check("fade_out_lvl", {8'h0, rgb_now()},
            FADE_ON != 0 ? {8'h0, {3{8'(255 * (256 - 64 * k) / 256)}}} : 32'hFFFFFF);
      tick();
    end
    check("fade_out_done_cnt", 32'(done_cnt - base), 32'(FADE_ON));

    // Fade back up to full.
    fade_req = 1; fade_dir = 0; tick();
    repeat (4) begin frame_start = 1; tick(); tick(); end
    tick();
    check("fade_in_full", {8'h0, rgb_now()}, 32'hFFFFFF);

    // Reverse mid-fade at level 128.
    base = done_cnt;
    fade_req = 1; fade_dir = 1; tick();
    frame_start = 1; tick(); frame_start = 1; tick();
    fade_req = 1; fade_dir = 0; tick();
    frame_start = 1; tick(); tick();
    check("reverse_192", {8'h0, rgb_now()}, FADE_ON != 0 ? 32'hBFBFBF : 32'hFFFFFF);
    frame_start = 1; tick();
    check("reverse_done", {31'h0, fade_done}, 32'(FADE_ON));
    tick();
    check("reverse_256", {8'h0, rgb_now()}, 32'hFFFFFF);
    check("reverse_done_cnt", 32'(done_cnt - base), 32'(FADE_ON));

    // Request toward the current target while idle.
    fade_req = 1; fade_dir = 0; repeat (4) tick();

    // Reset mid-fade.
    base = done_cnt;
    fade_req = 1; fade_dir = 1; tick();
    frame_start = 1; tick();
    Reset_n = 0; tick(); Reset_n = 1;
    check("rst_mid_busy", {31'h0, fade_busy}, 32'h0);
    repeat (3) tick();
    check("rst_mid_level", {8'h0, rgb_now()}, 32'hFFFFFF);
    check("rst_mid_no_done", 32'(done_cnt - base), 32'h0);

    // Random traffic.
    for (int c = 0; c < 4000; c++) begin
      Reset_n   = ($urandom_range(0, 499) != 0);
      pix_valid = ($urandom_range(0, 3) != 0);
      DrawX     = 10'($urandom_range(0, 1023));
      layer_hit = NL'($urandom);
      for (int i = 0; i < NL; i++)
        layer_idx[i*IW +: IW] = ($urandom_range(0, 2) == 0) ? 5'd0 : IW'($urandom);
      pal_wr_en   = ($urandom_range(0, 7) == 0);
      pal_wr_addr = IW'($urandom);
      pal_wr_data = 24'($urandom);
      frame_start = ($urandom_range(0, 5) == 0);
      fade_req    = ($urandom_range(0, 39) == 0);
      fade_dir    = 1'($urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
